// File: rtl/count_dec_pkg.sv
// rtl/count_dec_pkg.sv - shared state and delta-class types for the count stream decoder
package count_dec_pkg;

    typedef enum logic [1:0] {EMPTY, SEEDED, TRAIN, LOCKED} state_t;
    typedef enum logic [2:0] {UP1, DN1, UP2, DN2, BAD} cls_t;

    function automatic logic cls_is_down(input cls_t c);
        return (c == DN1) || (c == DN2);
    endfunction

    function automatic logic cls_is_step2(input cls_t c);
        return (c == UP2) || (c == DN2);
    endfunction

endpackage

// File: rtl/count_delta_class.sv
// rtl/count_delta_class.sv - combinational classification of the delta between two samples
module count_delta_class
    import count_dec_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] last,
    input  logic [W-1:0] q,
    output cls_t         cls
);

    logic [W-1:0] d;

    // Modular subtraction makes wrap-around transitions fall into the normal classes.
    assign d = q - last;

    always_comb begin
        cls = BAD;
        if (d == W'(1))
            cls = UP1;
        else if (d == {W{1'b1}})
            cls = DN1;
        else if (d == W'(2))
            cls = UP2;
        else if (d == {{(W-1){1'b1}}, 1'b0})
            cls = DN2;
    end

endmodule

// File: rtl/count_stream_decoder.sv
// rtl/count_stream_decoder.sv - locks onto an up/down step-1/2 count stream and predicts the next value
module count_stream_decoder
    import count_dec_pkg::*;
#(
    parameter int W      = 4,
    parameter int LOCK_N = 2,
    parameter int ECW    = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           valid,
    input  logic [W-1:0]   q,
    output logic           locked,
    output logic           down,
    output logic           step,
    output logic [W-1:0]   pred,
    output logic           err,
    output logic           mode_chg,
    output logic [ECW-1:0] err_cnt
);

    state_t       state, state_n;
    cls_t         cand, cand_n, cls;
    logic [3:0]   run, run_n, run_inc;
    logic [W-1:0] last;
    logic [W-1:0] off_n;
    logic         err_n, chg_n;

    count_delta_class #(.W(W)) u_class (
        .last (last),
        .q    (q),
        .cls  (cls)
    );

    assign run_inc = run + 4'd1;

    always_comb begin
        state_n = state;
        cand_n  = cand;
        run_n   = run;
        err_n   = 1'b0;
        chg_n   = 1'b0;
        if (valid) begin
            case (state)
                EMPTY: state_n = SEEDED;
                SEEDED: begin
                    if (cls != BAD) begin
                        cand_n  = cls;
                        run_n   = 4'd1;
                        state_n = (LOCK_N == 1) ? LOCKED : TRAIN;
                    end
                end
                TRAIN: begin
                    if (cls == BAD) begin
                        run_n   = 4'd0;
                        state_n = SEEDED;
                    end else if (cls == cand) begin
                        run_n = run_inc;
                        if (run_inc == 4'(LOCK_N))
                            state_n = LOCKED;
                    end else begin
                        cand_n = cls;
                        run_n  = 4'd1;
                    end
                end
                LOCKED: begin
                    if (cls == BAD) begin
                        err_n   = 1'b1;
                        run_n   = 4'd0;
                        state_n = SEEDED;
                    end else if (cls != cand) begin
                        chg_n   = 1'b1;
                        cand_n  = cls;
                        run_n   = 4'd1;
                        state_n = (LOCK_N == 1) ? LOCKED : TRAIN;
                    end
                end
                default: state_n = EMPTY;
            endcase
        end
    end

    // Signed step as a W-bit modular offset for the prediction.
    always_comb begin
        case (cand_n)
            UP1:     off_n = W'(1);
            DN1:     off_n = {W{1'b1}};
            UP2:     off_n = W'(2);
            DN2:     off_n = {{(W-1){1'b1}}, 1'b0};
            default: off_n = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            cand     <= UP1;
            run      <= 4'd0;
            last     <= '0;
            locked   <= 1'b0;
            down     <= 1'b0;
            step     <= 1'b0;
            pred     <= '0;
            err      <= 1'b0;
            mode_chg <= 1'b0;
            err_cnt  <= '0;
        end else begin
            err      <= err_n;
            mode_chg <= chg_n;
            if (valid) begin
                state  <= state_n;
                cand   <= cand_n;
                run    <= run_n;
                last   <= q;
                locked <= (state_n == LOCKED);
                down   <= cls_is_down(cand_n);
                step   <= cls_is_step2(cand_n);
                pred   <= q + off_n;
            end
            if (err_n && (err_cnt != {ECW{1'b1}}))
                err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule
